// File: rtl/wb_commit_rf.sv
// ---------------------------------------------------------------------------
// wb_commit_rf : writeback / commit stage of the NPC core.
//
// Accepts retiring instructions from the memory stage over a valid/ready
// handshake, writes the 32 x XLEN general purpose register file, publishes
// the committed instruction word and sequences the ebreak halt that the
// simulation DPI model waits on.
//
// Optional feature macro:
//   WB_RETIRE_CNT_EN - when defined, a 64-bit retired-instruction counter is
//                      implemented; when undefined retire_cnt is tied to 0.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   in_valid/in_ready   handshake with the memory stage
//   in_inst             retiring instruction word
//   in_rd/in_wen        destination register and its write enable
//   in_wdata            writeback data
//   in_is_ebreak        retiring instruction is ebreak
//   raddr1/2, rdata1/2  decode read ports (combinational, write-first bypass)
//   rf_flat             all GPRs, x[i] = rf_flat[XLEN*i +: XLEN], no bypass
//   commit_valid        one-cycle pulse per retired instruction
//   commit_inst         last retired instruction word
//   is_break            halt reached, sticky until reset
//   halt_code           x10 (a0) value at ebreak commit
//   retire_cnt          retired-instruction count
// ---------------------------------------------------------------------------
module wb_commit_rf #(
  parameter int XLEN       = 64,
  parameter int HALT_DELAY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [4:0]           in_rd,
  input  logic                 in_wen,
  input  logic [XLEN-1:0]      in_wdata,
  input  logic                 in_is_ebreak,
  input  logic [4:0]           raddr1,
  input  logic [4:0]           raddr2,
  output logic [XLEN-1:0]      rdata1,
  output logic [XLEN-1:0]      rdata2,
  output logic [32*XLEN-1:0]   rf_flat,
  output logic                 commit_valid,
  output logic [31:0]          commit_inst,
  output logic                 is_break,
  output logic [XLEN-1:0]      halt_code,
  output logic [63:0]          retire_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  // The drain counter is loaded with HALT_DELAY-1 so that, together with the
  // DRAIN->HALTED transition and the registered is_break, the halt flag rises
  // exactly HALT_DELAY+1 cycles after the ebreak transfer edge.
  localparam logic [3:0] HaltLoad = 4'(HALT_DELAY - 1);

  state_e            state_q, stateD;
  logic [3:0]        haltCnt_q, haltCntD;
  logic [XLEN-1:0]   gpr_q [32];
  logic              commitValid_q;
  logic [31:0]       commitInst_q;
  logic              isBreak_q;
  logic [XLEN-1:0]   haltCode_q;

  logic              xfer;
  logic              doWrite;
  logic [XLEN-1:0]   x10Bypass;

  // A transfer needs the stage to be in RUN; in_ready is a pure function of
  // the state so the memory stage never sees a combinational loop through
  // in_valid. Writes to x0 are dropped here, which keeps x0 at its reset 0.
  assign xfer    = in_valid && in_ready;
  assign doWrite = xfer && in_wen && (in_rd != 5'd0);

  // State register and halt down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      haltCnt_q <= 4'd0;
    end else begin
      state_q   <= stateD;
      haltCnt_q <= haltCntD;
    end
  end

  // Next-state logic: an ebreak transfer starts the drain, the counter then
  // runs down to zero before the stage parks in HALTED for good.
  always_comb begin
    stateD   = state_q;
    haltCntD = haltCnt_q;
    in_ready = 1'b0;
    case (state_q)
      RUN: begin
        in_ready = 1'b1;
        if (xfer && in_is_ebreak) begin
          stateD   = DRAIN;
          haltCntD = HaltLoad;
        end
      end
      DRAIN: begin
        if (haltCnt_q == 4'd0) begin
          stateD = HALTED;
        end else begin
          haltCntD = haltCnt_q - 4'd1;
        end
      end
      HALTED: begin
        stateD = HALTED;
      end
      default: begin
        stateD = RUN;
      end
    endcase
  end

  // Register file storage. Every entry, x0 included, is cleared on reset;
  // x0 is never written afterwards because doWrite excludes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (doWrite) begin
      gpr_q[in_rd] <= in_wdata;
    end
  end

  // Decode read ports with write-first bypass so decode sees a value being
  // retired in the same cycle. Address 0 is forced to zero.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != 5'd0) begin
      rdata1 = (doWrite && (in_rd == raddr1)) ? in_wdata : gpr_q[raddr1];
    end
    if (raddr2 != 5'd0) begin
      rdata2 = (doWrite && (in_rd == raddr2)) ? in_wdata : gpr_q[raddr2];
    end
  end

  // The halt code must include an ebreak that itself writes a0.
  assign x10Bypass = (doWrite && (in_rd == 5'd10)) ? in_wdata : gpr_q[10];

  // Architectural state for the DPI model shows registered values only.
  for (genvar g = 0; g < 32; g++) begin : gFlat
    assign rf_flat[XLEN*g +: XLEN] = gpr_q[g];
  end

  // Commit reporting: one-cycle pulse, the instruction word held until the
  // next commit, halt code captured on the ebreak transfer and a sticky
  // is_break that is registered one cycle after the FSM parks in HALTED.
  always_ff @(posedge clk) begin
    if (rst) begin
      commitValid_q <= 1'b0;
      commitInst_q  <= 32'h0;
      isBreak_q     <= 1'b0;
      haltCode_q    <= '0;
    end else begin
      commitValid_q <= xfer;
      if (xfer) begin
        commitInst_q <= in_inst;
      end
      if (xfer && in_is_ebreak) begin
        haltCode_q <= x10Bypass;
      end
      if (state_q == HALTED) begin
        isBreak_q <= 1'b1;
      end
    end
  end

  assign commit_valid = commitValid_q;
  assign commit_inst  = commitInst_q;
  assign is_break     = isBreak_q;
  assign halt_code    = haltCode_q;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retireCnt_q;

  // Retired-instruction counter, wraps naturally modulo 2^64.
  always_ff @(posedge clk) begin
    if (rst) begin
      retireCnt_q <= 64'h0;
    end else if (xfer) begin
      retireCnt_q <= retireCnt_q + 64'd1;
    end
  end

  assign retire_cnt = retireCnt_q;
`else
  assign retire_cnt = 64'h0;
`endif

endmodule

// File: tb/tb_wb_commit_rf.sv
// ---------------------------------------------------------------------------
// tb_wb_commit_rf : directed self-checking bench for wb_commit_rf.
// Inputs are driven 1 ns after the rising edge and outputs are sampled there
// or after a further 1 ns settle for combinational reads.
// ---------------------------------------------------------------------------
module tb_wb_commit_rf;

`ifdef WB_RETIRE_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_inst;
  logic [4:0]    in_rd;
  logic          in_wen;
  logic [63:0]   in_wdata;
  logic          in_is_ebreak;
  logic [4:0]    raddr1;
  logic [4:0]    raddr2;
  logic [63:0]   rdata1;
  logic [63:0]   rdata2;
  logic [2047:0] rf_flat;
  logic          commit_valid;
  logic [31:0]   commit_inst;
  logic          is_break;
  logic [63:0]   halt_code;
  logic [63:0]   retire_cnt;

  int checkCnt = 0;
  int passCnt  = 0;
  int failCnt  = 0;
  longint unsigned commits = 0;

  wb_commit_rf #(.XLEN(64), .HALT_DELAY(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_rd        (in_rd),
    .in_wen       (in_wen),
    .in_wdata     (in_wdata),
    .in_is_ebreak (in_is_ebreak),
    .raddr1       (raddr1),
    .raddr2       (raddr2),
    .rdata1       (rdata1),
    .rdata2       (rdata2),
    .rf_flat      (rf_flat),
    .commit_valid (commit_valid),
    .commit_inst  (commit_inst),
    .is_break     (is_break),
    .halt_code    (halt_code),
    .retire_cnt   (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register i as seen in the flattened architectural view.
  function automatic logic [63:0] gpr(input int i);
    return rf_flat[64*i +: 64];
  endfunction

  // Expected retire count: the counter only exists with the macro defined.
  function automatic logic [63:0] expCnt();
    return CntEn ? 64'(commits) : 64'h0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCnt++;
    assert (observed === expected) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rd,
                               input logic wen, input logic [63:0] wdata,
                               input logic [31:0] inst, input logic ebrk);
    in_valid     = v;
    in_rd        = rd;
    in_wen       = wen;
    in_wdata     = wdata;
    in_inst      = inst;
    in_is_ebreak = ebrk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 32'h0, 1'b0);
    step();
    step();
    rst = 1'b0;

    // Reset state
    checkOutput("rst_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_cvalid", 64'(commit_valid), 64'd0);
    checkOutput("rst_cinst", 64'(commit_inst), 64'h0);
    checkOutput("rst_break", 64'(is_break), 64'd0);
    checkOutput("rst_hcode", halt_code, 64'h0);
    checkOutput("rst_cnt", retire_cnt, 64'h0);
    checkOutput("rst_rf_zero", 64'(rf_flat == '0), 64'd1);

    // First write to x5
    applyStimulus(1'b1, 5'd5, 1'b1, 64'hDEAD_BEEF_0000_0001, 32'h00a00293, 1'b0);
    step();
    commits++;
    applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 32'h0, 1'b0);
    checkOutput("wr_x5", gpr(5), 64'hDEAD_BEEF_0000_0001);
    checkOutput("wr_cvalid", 64'(commit_valid), 64'd1);
    checkOutput("wr_cinst", 64'(commit_inst), 64'h00a00293);
    checkOutput("wr_cnt", retire_cnt, expCnt());
    step();
    checkOutput("wr_cvalid_pulse", 64'(commit_valid), 64'd0);
    checkOutput("wr_cinst_hold", 64'(commit_inst), 64'h00a00293);

    // x0 protection, including the same-cycle read
    raddr1 = 5'd0;
    applyStimulus(1'b1, 5'd0, 1'b1, 64'hFFFF, 32'h0ff00013, 1'b0);
    #1;
    checkOutput("x0_rd_same", rdata1, 64'h0);
    step();
    commits++;
    applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 32'h0, 1'b0);
    checkOutput("x0_rf", gpr(0), 64'h0);
    checkOutput("x0_rd_after", rdata1, 64'h0);

    // Bypass: seed x7, plain read, then same-cycle overwrite
    applyStimulus(1'b1, 5'd7, 1'b1, 64'h5555, 32'h00000393, 1'b0);
    step();
    commits++;
    applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 32'h0, 1'b0);
    raddr1 = 5'd5;
    raddr2 = 5'd7;
    #1;
    checkOutput("rd_x5", rdata1, 64'hDEAD_BEEF_0000_0001);
    checkOutput("rd_x7_old", rdata2, 64'h5555);
    applyStimulus(1'b1, 5'd7, 1'b1, 64'h1234, 32'h12300393, 1'b0);
    #1;
    checkOutput("byp_x7", rdata2, 64'h1234);
    checkOutput("byp_rf_noby", gpr(7), 64'h5555);
    step();
    commits++;
    checkOutput("byp_x7_reg", gpr(7), 64'h1234);
    applyStimulus(1'b1, 5'd7, 1'b0, 64'h9999, 32'h00000013, 1'b0);
    #1;
    checkOutput("byp_nowen", rdata2, 64'h1234);
    step();
    commits++;
    checkOutput("nowen_x7", gpr(7), 64'h1234);
    checkOutput("nowen_cnt", retire_cnt, expCnt());

    // 100 back-to-back commits at full throughput
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 5'd20, 1'b1, 64'(i), 32'h00000a13, 1'b0);
      step();
      commits++;
      checkOutput("b2b_cvalid", 64'(commit_valid), 64'd1);
    end
    applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 32'h0, 1'b0);
    checkOutput("b2b_x20", gpr(20), 64'd99);
    checkOutput("b2b_cnt", retire_cnt, expCnt());
    checkOutput("b2b_ready", 64'(in_ready), 64'd1);

    // Halt sequence: x10 = 0, then ebreak
    applyStimulus(1'b1, 5'd10, 1'b1, 64'h0, 32'h00000513, 1'b0);
    step();
    commits++;
    applyStimulus(1'b1, 5'd0, 1'b0, 64'h0, 32'h00100073, 1'b1);
    step();
    commits++;
    // DRAIN pulses try to write x5 and must be ignored
    applyStimulus(1'b1, 5'd5, 1'b1, 64'hAAAA, 32'h0aa00293, 1'b0);
    checkOutput("eb_ready", 64'(in_ready), 64'd0);
    checkOutput("eb_cvalid", 64'(commit_valid), 64'd1);
    checkOutput("eb_cinst", 64'(commit_inst), 64'h00100073);
    checkOutput("eb_break1", 64'(is_break), 64'd0);
    checkOutput("eb_cnt", retire_cnt, expCnt());
    step();
    checkOutput("eb_cvalid_drain", 64'(commit_valid), 64'd0);
    checkOutput("eb_break2", 64'(is_break), 64'd0);
    step();
    checkOutput("eb_break3", 64'(is_break), 64'd0);
    step();
    checkOutput("eb_break_rise", 64'(is_break), 64'd1);
    checkOutput("eb_hcode", halt_code, 64'h0);
    step();
    step();
    checkOutput("eb_break_stay", 64'(is_break), 64'd1);
    checkOutput("eb_halt_ready", 64'(in_ready), 64'd0);
    checkOutput("eb_x5_frozen", gpr(5), 64'hDEAD_BEEF_0000_0001);
    checkOutput("eb_cinst_frozen", 64'(commit_inst), 64'h00100073);
    checkOutput("eb_cnt_frozen", retire_cnt, expCnt());
    checkOutput("eb_cvalid_halt", 64'(commit_valid), 64'd0);
    applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 32'h0, 1'b0);

    // Reset out of HALTED, then an ebreak that writes a0 and is aborted
    rst = 1'b1;
    step();
    rst = 1'b0;
    commits = 0;
    checkOutput("rh_ready", 64'(in_ready), 64'd1);
    checkOutput("rh_break", 64'(is_break), 64'd0);
    applyStimulus(1'b1, 5'd10, 1'b1, 64'h77, 32'h00100073, 1'b1);
    step();
    commits++;
    applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 32'h0, 1'b0);
    checkOutput("ebw_x10", gpr(10), 64'h77);
    checkOutput("ebw_hcode", halt_code, 64'h77);
    checkOutput("ebw_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    commits = 0;
    checkOutput("rd_ready", 64'(in_ready), 64'd1);
    checkOutput("rd_rf_zero", 64'(rf_flat == '0), 64'd1);
    checkOutput("rd_hcode", halt_code, 64'h0);
    checkOutput("rd_cnt", retire_cnt, 64'h0);
    checkOutput("rd_cinst", 64'(commit_inst), 64'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("rd_no_break", 64'(is_break), 64'd0);
    end

    // Counter wrap (only meaningful with the counter present)
`ifdef WB_RETIRE_CNT_EN
    force dut.retireCnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retireCnt_q;
    #1;
    checkOutput("wrap_pre", retire_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    applyStimulus(1'b1, 5'd3, 1'b1, 64'h3, 32'h00300193, 1'b0);
    step();
    applyStimulus(1'b0, 5'd0, 1'b0, 64'h0, 32'h0, 1'b0);
    checkOutput("wrap_cnt", retire_cnt, 64'h0);
    checkOutput("wrap_x3", gpr(3), 64'h3);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
